mp_reg_file: RTL and testbench

MP_REG_FILE -- requirements
Module: mp_reg_file

---
 rtl/mp_reg_file.sv | 94 +++++++++
 tb/tb_mp_reg_file.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mp_reg_file.sv
// Multi-port register file: two write ports, NUM_RD combinational read ports, register 0 hardwired to zero.
// After reset a CLEAR sweep zeroes registers 1..DEPTH-1 before ready rises; define REGFILE_BYPASS_EN for write-to-read bypass.
module mp_reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr0_en,
  input  logic                       wr1_en,
  input  logic [ADDR_W-1:0]          wr0_addr,
  input  logic [ADDR_W-1:0]          wr1_addr,
  input  logic [DATA_W-1:0]          wr0_data,
  input  logic [DATA_W-1:0]          wr1_data,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic                       ready,
  output logic                       wr_conflict
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic run_p0;
  logic wr0_ok_p0;
  logic wr1_ok_p0;
  logic conflict_p0;
  logic conflict_p1;

  // p0: qualify write requests in the current cycle
  assign run_p0      = (state == RUN) && !rst;
  assign wr0_ok_p0   = run_p0 && wr0_en && (wr0_addr != '0);
  assign wr1_ok_p0   = run_p0 && wr1_en && (wr1_addr != '0);
  assign conflict_p0 = wr0_ok_p0 && wr1_ok_p0 && (wr0_addr == wr1_addr);

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR: if (clr_ptr == LAST_ADDR) state_nxt = RUN;
      RUN:   state_nxt = RUN;
    endcase
  end

  // p1: control state and the registered conflict pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR;
      clr_ptr     <= ADDR_W'(1);
      conflict_p1 <= 1'b0;
    end else begin
      state       <= state_nxt;
      conflict_p1 <= conflict_p0;
      if (state == CLEAR) clr_ptr <= clr_ptr + ADDR_W'(1);
    end
  end

  // Storage has no reset; port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!rst && (state == CLEAR)) mem[clr_ptr] <= '0;
    if (wr0_ok_p0) mem[wr0_addr] <= wr0_data;
    if (wr1_ok_p0) mem[wr1_addr] <= wr1_data;
  end

  always_comb begin
    logic [ADDR_W-1:0] lane_addr;
    logic [DATA_W-1:0] lane_data;
    lane_addr = '0;
    lane_data = '0;
    rd_data   = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      lane_addr = rd_addr[i*ADDR_W +: ADDR_W];
      lane_data = '0;
      if (run_p0 && (lane_addr != '0)) begin
        lane_data = mem[lane_addr];
`ifdef REGFILE_BYPASS_EN
        if (wr0_ok_p0 && (wr0_addr == lane_addr)) lane_data = wr0_data;
        if (wr1_ok_p0 && (wr1_addr == lane_addr)) lane_data = wr1_data;
`endif
      end
      rd_data[i*DATA_W +: DATA_W] = lane_data;
    end
  end

  assign ready       = (state == RUN);
  assign wr_conflict = conflict_p1;

endmodule

// File: tb/tb_mp_reg_file.sv
// Self-checking bench for mp_reg_file: directed vector table, clear/reset sequences, and randomized traffic
// checked against a behavioural model. Expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_mp_reg_file;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 32;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst = 1'b1;
  logic                     wr0_en = 1'b0, wr1_en = 1'b0;
  logic [ADDR_W-1:0]        wr0_addr = '0, wr1_addr = '0;
  logic [DATA_W-1:0]        wr0_data = '0, wr1_data = '0;
  logic [ADDR_W-1:0]        ra0 = '0, ra1 = '0;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [DATA_W-1:0]        rd0, rd1;
  logic                     ready, wr_conflict;

  assign rd_addr    = {ra1, ra0};
  assign {rd1, rd0} = rd_data;

  mp_reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .clk(clk), .rst(rst),
    .wr0_en(wr0_en), .wr1_en(wr1_en),
    .wr0_addr(wr0_addr), .wr1_addr(wr1_addr),
    .wr0_data(wr0_data), .wr1_data(wr1_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .ready(ready), .wr_conflict(wr_conflict)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model: clear countdown, register contents, last-cycle conflict flag.
  logic [DATA_W-1:0] m_mem [DEPTH];
  int                m_cnt = 31;
  logic              m_conflict = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] m_rd(input logic [ADDR_W-1:0] a);
    if (rst || (m_cnt != 0) || (a == 0)) return '0;
    if (BYP && wr1_en && (wr1_addr == a)) return wr1_data;
    if (BYP && wr0_en && (wr0_addr == a)) return wr0_data;
    return m_mem[a];
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_cnt      = 31;
      m_conflict = 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      m_conflict = 1'b0;
      if (m_cnt == 0) for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
    end else begin
      m_conflict = wr0_en && wr1_en && (wr0_addr == wr1_addr) && (wr0_addr != 0);
      if (wr0_en && (wr0_addr != 0)) m_mem[wr0_addr] = wr0_data;
      if (wr1_en && (wr1_addr != 0)) m_mem[wr1_addr] = wr1_data;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wr0_en = 1'b0; wr1_en = 1'b0;
    wr0_addr = '0; wr1_addr = '0;
    wr0_data = '0; wr1_data = '0;
  endtask

  typedef struct {
    logic              w0e;
    logic [ADDR_W-1:0] w0a;
    logic [DATA_W-1:0] w0d;
    logic              w1e;
    logic [ADDR_W-1:0] w1a;
    logic [DATA_W-1:0] w1d;
    logic [ADDR_W-1:0] r0, r1;
    logic [DATA_W-1:0] e0, e1, e0b, e1b;
    logic              ec;
  } vec_t;

  function automatic vec_t mk(input int w0e, w0a, w0d, w1e, w1a, w1d, r0, r1, e0, e1, e0b, e1b, ec);
    vec_t v;
    v.w0e = w0e[0]; v.w0a = w0a[ADDR_W-1:0]; v.w0d = w0d;
    v.w1e = w1e[0]; v.w1a = w1a[ADDR_W-1:0]; v.w1d = w1d;
    v.r0 = r0[ADDR_W-1:0]; v.r1 = r1[ADDR_W-1:0];
    v.e0 = e0; v.e1 = e1; v.e0b = e0b; v.e1b = e1b;
    v.ec = ec[0];
    return v;
  endfunction

  vec_t tbl [12];

  initial begin
    logic [ADDR_W-1:0] a5;
    for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;

    //         w0e w0a w0d      w1e w1a w1d      r0  r1  e0(off) e1(off) e0(byp) e1(byp) conflict
    tbl[0]  = mk(1,  4, 10,       0, 0, 0,         0,  0,  0,      0,      0,      0,      0);
    tbl[1]  = mk(0,  0, 0,        0, 0, 0,         0,  4,  0,      10,     0,      10,     0);
    tbl[2]  = mk(1,  5, 'hAAAA,   1, 5, 'h5555,    5,  5,  0,      0,      'h5555, 'h5555, 1);
    tbl[3]  = mk(0,  0, 0,        0, 0, 0,         5,  4,  'h5555, 10,     'h5555, 10,     0);
    tbl[4]  = mk(1,  0, 'h1234,   1, 0, 'hFFFF,    0,  0,  0,      0,      0,      0,      0);
    tbl[5]  = mk(0,  0, 0,        0, 0, 0,         0,  5,  0,      'h5555, 0,      'h5555, 0);
    tbl[6]  = mk(1, 29, 'h1234,   0, 0, 0,         29, 4,  0,      10,     'h1234, 10,     0);
    tbl[7]  = mk(0,  0, 0,        0, 0, 0,         29, 29, 'h1234, 'h1234, 'h1234, 'h1234, 0);
    tbl[8]  = mk(1,  7, 'h11,     1, 8, 'h22,      7,  8,  0,      0,      'h11,   'h22,   0);
    tbl[9]  = mk(0,  0, 0,        0, 0, 0,         8,  7,  'h22,   'h11,   'h22,   'h11,   0);
    tbl[10] = mk(1,  9, 'h33,     0, 9, 'h44,      9,  9,  0,      0,      'h33,   'h33,   0);
    tbl[11] = mk(0,  0, 0,        0, 0, 0,         9,  9,  'h33,   'h33,   'h33,   'h33,   0);

    // Reset held for two cycles
    rst = 1'b1; idle(); ra0 = 5'd4; ra1 = 5'd31;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_conflict", 32'(wr_conflict), 32'd0);
      chk("rst_rd0", rd0, 32'd0);
      chk("rst_rd1", rd1, 32'd0);
    end

    // Clear sweep: ready rises after the 31st edge
    rst = 1'b0;
    for (int e = 1; e <= 31; e++) begin
      #1;
      chk("clear_rd0", rd0, 32'd0);
      tick();
      chk("clear_ready", 32'(ready), (e == 31) ? 32'd1 : 32'd0);
    end
    for (int a = 0; a < DEPTH; a += 2) begin
      ra0 = 5'(a); ra1 = 5'(a + 1);
      #1;
      chk("post_clear_rd0", rd0, 32'd0);
      chk("post_clear_rd1", rd1, 32'd0);
    end

    // Directed vectors in RUN
    for (int i = 0; i < 12; i++) begin
      wr0_en = tbl[i].w0e; wr0_addr = tbl[i].w0a; wr0_data = tbl[i].w0d;
      wr1_en = tbl[i].w1e; wr1_addr = tbl[i].w1a; wr1_data = tbl[i].w1d;
      ra0 = tbl[i].r0; ra1 = tbl[i].r1;
      #1;
      chk($sformatf("vec%0d_rd0", i), rd0, BYP ? tbl[i].e0b : tbl[i].e0);
      chk($sformatf("vec%0d_rd1", i), rd1, BYP ? tbl[i].e1b : tbl[i].e1);
      tick();
      chk($sformatf("vec%0d_conflict", i), 32'(wr_conflict), 32'(tbl[i].ec));
      chk($sformatf("vec%0d_ready", i), 32'(ready), 32'd1);
    end

    // One-cycle reset in RUN, with writes attempted throughout the restarted clear
    idle(); rst = 1'b1; ra0 = 5'd4; ra1 = 5'd29;
    #1;
    chk("midrst_rd0", rd0, 32'd0);
    tick();
    chk("midrst_ready", 32'(ready), 32'd0);
    chk("midrst_conflict", 32'(wr_conflict), 32'd0);
    rst = 1'b0;
    for (int e = 1; e <= 31; e++) begin
      a5 = (e == 1) ? 5'd1 : 5'(e - 1);
      wr0_en = 1'b1; wr0_addr = a5;   wr0_data = $urandom | 32'h1;
      wr1_en = 1'b1; wr1_addr = 5'd4; wr1_data = $urandom | 32'h1;
      ra0 = a5; ra1 = 5'd4;
      #1;
      chk("reclear_rd0", rd0, 32'd0);
      chk("reclear_rd1", rd1, 32'd0);
      tick();
      chk("reclear_ready", 32'(ready), (e == 31) ? 32'd1 : 32'd0);
      chk("reclear_conflict", 32'(wr_conflict), 32'd0);
    end
    idle();
    for (int a = 0; a < DEPTH; a += 2) begin
      ra0 = 5'(a); ra1 = 5'(a + 1);
      #1;
      chk("reclear_post_rd0", rd0, 32'd0);
      chk("reclear_post_rd1", rd1, 32'd0);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      rst      = ($urandom_range(0, 99) == 0);
      wr0_en   = 1'($urandom_range(0, 1));
      wr1_en   = 1'($urandom_range(0, 1));
      wr0_addr = 5'($urandom_range(0, 31));
      wr1_addr = ($urandom_range(0, 3) == 0) ? wr0_addr : 5'($urandom_range(0, 31));
      wr0_data = $urandom;
      wr1_data = $urandom;
      case ($urandom_range(0, 2))
        0:       ra0 = wr0_addr;
        1:       ra0 = wr1_addr;
        default: ra0 = 5'($urandom_range(0, 31));
      endcase
      ra1 = ($urandom_range(0, 1) == 0) ? wr1_addr : 5'($urandom_range(0, 31));
      #1;
      chk("rand_rd0", rd0, m_rd(ra0));
      chk("rand_rd1", rd1, m_rd(ra1));
      tick();
      chk("rand_ready", 32'(ready), (m_cnt == 0) ? 32'd1 : 32'd0);
      chk("rand_conflict", 32'(wr_conflict), 32'(m_conflict));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
